// File: rtl/fetch_pkg.sv
// Shared fetch-side definitions: reset vector, fetch FSM states, the IF slot
// payload and the control-flow opcodes decoded by the redirect resolver.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_slot_t;

  function automatic logic is_ctrl_flow(input logic [6:0] opcode);
    return (opcode == BRANCH) || (opcode == JAL) || (opcode == JALR);
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry hold register that parks the IF slot (PC + instruction) while
// the hazard unit freezes fetch.
module fetch_hold_buf (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        capture,
  input  logic        release_en,
  input  logic        drop,
  input  logic [63:0] din,
  output logic [63:0] dout,
  output logic        full
);

  logic [63:0] data_q;
  logic        full_q;

  // Only the first stall cycle loads; later cycles keep the parked slot.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (drop || release_en) begin
      full_q <= 1'b0;
    end else if (capture && !full_q) begin
      data_q <= din;
      full_q <= 1'b1;
    end
  end

  assign dout = data_q;
  assign full = full_q;

endmodule

// File: rtl/fetch_redirect.sv
// Fetch PC generator with branch/jump redirect, IF/ID+ID/EX flush and a stall
// hold buffer. Define FETCH_REDIRECT_CNT_EN to add the redirect_cnt_o counter.
module fetch_redirect
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         pc_mux_sel_i,
  input  logic [31:0]  pc_taken_i,
  input  logic         stall_i,
  input  logic [31:0]  imem_rdata_i,
  output logic [31:0]  imem_addr_o,
  output logic [31:0]  if_pc_o,
  output logic [31:0]  if_instr_o,
  output logic         if_valid_o,
  output logic         flush_id_o,
  output logic         flush_ex_o,
  output logic         misalign_o,
`ifdef FETCH_REDIRECT_CNT_EN
  output logic [31:0]  redirect_cnt_o,
`endif
  output fetch_state_e state_dbg
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, if_pc_q;
  logic         misalign_q;
  logic         redirect, fetch_stall;
  logic         buf_capture, buf_release, buf_full;
  fetch_slot_t  buf_in, buf_out;

  assign redirect = pc_mux_sel_i;

  // Stall freezes the PC only while IF holds a real instruction. In BOOT and
  // FLUSH the slot is empty, so fetch keeps going and pc_q stays one word
  // ahead of the presented PC, which the hold buffer relies on.
  assign fetch_stall = stall_i && (state_q == RUN);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = redirect ? FLUSH : RUN;
      FLUSH:   state_d = redirect ? FLUSH : RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = word_align(pc_taken_i);
    end else if (!fetch_stall) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= pc_q;
      misalign_q <= redirect && (pc_taken_i[1:0] != 2'b00);
    end
  end

  // The slot shown on the first stall cycle is parked and stays on IF/ID up
  // to and including the release cycle, when the consumer finally takes it.
  assign buf_capture = stall_i && !redirect && (state_q == RUN);
  assign buf_release = !stall_i;
  assign buf_in      = '{pc: if_pc_q, instr: imem_rdata_i};

  fetch_hold_buf u_hold_buf (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .capture    (buf_capture),
    .release_en (buf_release),
    .drop       (redirect),
    .din        (buf_in),
    .dout       (buf_out),
    .full       (buf_full)
  );

  assign imem_addr_o = pc_q;
  assign if_pc_o     = buf_full ? buf_out.pc : if_pc_q;
  assign if_instr_o  = buf_full ? buf_out.instr : imem_rdata_i;
  assign if_valid_o  = buf_full || (state_q == RUN);
  assign flush_id_o  = redirect && rst_ni;
  assign flush_ex_o  = redirect && rst_ni;
  assign misalign_o  = misalign_q && rst_ni;
  assign state_dbg   = state_q;

`ifdef FETCH_REDIRECT_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (redirect && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign redirect_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_redirect.sv
// Bench for fetch_redirect: table of per-cycle stimulus with expected outputs,
// pushed to an expected queue on drive and popped when outputs are sampled.
module tb_fetch_redirect;
  import fetch_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         sel;
  logic [31:0]  tgt;
  logic         stall;
  logic [31:0]  imem_rdata;
  logic [31:0]  imem_addr;
  logic [31:0]  if_pc;
  logic [31:0]  if_instr;
  logic         if_valid;
  logic         flush_id;
  logic         flush_ex;
  logic         misalign;
  fetch_state_e state_dbg;
`ifdef FETCH_REDIRECT_CNT_EN
  logic [31:0]  redirect_cnt;
`endif

  fetch_redirect #(.RESET_PC(32'h0000_0100)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .pc_mux_sel_i (sel),
    .pc_taken_i   (tgt),
    .stall_i      (stall),
    .imem_rdata_i (imem_rdata),
    .imem_addr_o  (imem_addr),
    .if_pc_o      (if_pc),
    .if_instr_o   (if_instr),
    .if_valid_o   (if_valid),
    .flush_id_o   (flush_id),
    .flush_ex_o   (flush_ex),
    .misalign_o   (misalign),
`ifdef FETCH_REDIRECT_CNT_EN
    .redirect_cnt_o (redirect_cnt),
`endif
    .state_dbg    (state_dbg)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // synchronous instruction memory: data one cycle after the address
  always @(posedge clk) imem_rdata <= instr_of(imem_addr);

  typedef struct packed {
    logic         valid;
    logic [31:0]  pc;
    logic [31:0]  addr;
    logic         flush;
    logic         mis;
    fetch_state_e state;
    logic [31:0]  cnt;
  } exp_t;

  typedef struct packed {
    logic        rst_n;
    logic        sel;
    logic [31:0] tgt;
    logic        stall;
    exp_t        exp;
  } vec_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   row      = 0;

  function automatic vec_t mk(input logic r, input logic s, input logic [31:0] t,
                              input logic st, input logic v, input logic [31:0] pc,
                              input logic [31:0] addr, input logic fl, input logic mi,
                              input fetch_state_e sd, input logic [31:0] cnt);
    vec_t x;
    x.rst_n = r; x.sel = s; x.tgt = t; x.stall = st;
    x.exp.valid = v; x.exp.pc = pc; x.exp.addr = addr; x.exp.flush = fl;
    x.exp.mis = mi; x.exp.state = sd; x.exp.cnt = cnt;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h, expected %h", name, row, act, expv);
    end
  endtask

  // scoreboard: pop the expectation pushed when this cycle was driven
  task automatic compare();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard row %0d: expected queue empty", row);
      return;
    end
    e = exp_q.pop_front();
    check("if_valid", 32'(if_valid), 32'(e.valid));
    check("if_pc", if_pc, e.pc);
    check("imem_addr", imem_addr, e.addr);
    check("flush_id", 32'(flush_id), 32'(e.flush));
    check("flush_ex", 32'(flush_ex), 32'(e.flush));
    check("misalign", 32'(misalign), 32'(e.mis));
    check("state", 32'(state_dbg), 32'(e.state));
    if (e.valid) check("if_instr", if_instr, instr_of(e.pc));
`ifdef FETCH_REDIRECT_CNT_EN
    check("redirect_cnt", redirect_cnt, e.cnt);
`endif
  endtask

  // driver: inputs at negedge, outputs sampled 2 ns later
  task automatic apply(input vec_t v);
    @(negedge clk);
    rst_n = v.rst_n;
    sel   = v.sel;
    tgt   = v.tgt;
    stall = v.stall;
    exp_q.push_back(v.exp);
    #2;
    compare();
    row++;
  endtask

  vec_t tab_a[10];
  vec_t tab_c[20];

  initial begin
    rst_n = 1'b0; sel = 1'b0; tgt = '0; stall = 1'b0;
    repeat (2) @(posedge clk);

    // reset, boot and a three-cycle stall at pc_q=0x10C
    tab_a[0] = mk(0, 1, 32'h2002, 0, 0, 32'h0,   32'h100, 0, 0, BOOT, 0);
    tab_a[1] = mk(1, 0, 32'h0,    0, 0, 32'h0,   32'h100, 0, 0, BOOT, 0);
    tab_a[2] = mk(1, 0, 32'h0,    0, 1, 32'h100, 32'h104, 0, 0, RUN,  0);
    tab_a[3] = mk(1, 0, 32'h0,    0, 1, 32'h104, 32'h108, 0, 0, RUN,  0);
    tab_a[4] = mk(1, 0, 32'h0,    1, 1, 32'h108, 32'h10C, 0, 0, RUN,  0);
    tab_a[5] = mk(1, 0, 32'h0,    1, 1, 32'h108, 32'h10C, 0, 0, RUN,  0);
    tab_a[6] = mk(1, 0, 32'h0,    1, 1, 32'h108, 32'h10C, 0, 0, RUN,  0);
    tab_a[7] = mk(1, 0, 32'h0,    0, 1, 32'h108, 32'h10C, 0, 0, RUN,  0);
    tab_a[8] = mk(1, 0, 32'h0,    0, 1, 32'h10C, 32'h110, 0, 0, RUN,  0);
    tab_a[9] = mk(1, 0, 32'h0,    0, 1, 32'h110, 32'h114, 0, 0, RUN,  0);

    // redirects, stall+redirect, misalign, wrap, reset mid-stall,
    // back-to-back redirects and reset mid-FLUSH
    tab_c[0]  = mk(1, 1, 32'h2000,      0, 1, 32'h13C,       32'h140,       1, 0, RUN,   0);
    tab_c[1]  = mk(1, 0, 32'h0,         0, 0, 32'h140,       32'h2000,      0, 0, FLUSH, 1);
    tab_c[2]  = mk(1, 0, 32'h0,         0, 1, 32'h2000,      32'h2004,      0, 0, RUN,   1);
    tab_c[3]  = mk(1, 0, 32'h0,         1, 1, 32'h2004,      32'h2008,      0, 0, RUN,   1);
    tab_c[4]  = mk(1, 1, 32'h3000,      1, 1, 32'h2004,      32'h2008,      1, 0, RUN,   1);
    tab_c[5]  = mk(1, 0, 32'h0,         0, 0, 32'h2008,      32'h3000,      0, 0, FLUSH, 2);
    tab_c[6]  = mk(1, 0, 32'h0,         0, 1, 32'h3000,      32'h3004,      0, 0, RUN,   2);
    tab_c[7]  = mk(1, 1, 32'h2002,      0, 1, 32'h3004,      32'h3008,      1, 0, RUN,   2);
    tab_c[8]  = mk(1, 0, 32'h0,         0, 0, 32'h3008,      32'h2000,      0, 1, FLUSH, 3);
    tab_c[9]  = mk(1, 0, 32'h0,         0, 1, 32'h2000,      32'h2004,      0, 0, RUN,   3);
    tab_c[10] = mk(1, 1, 32'hFFFF_FFFC, 0, 1, 32'h2004,      32'h2008,      1, 0, RUN,   3);
    tab_c[11] = mk(1, 0, 32'h0,         0, 0, 32'h2008,      32'hFFFF_FFFC, 0, 0, FLUSH, 4);
    tab_c[12] = mk(1, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 32'h0,         0, 0, RUN,   4);
    tab_c[13] = mk(0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 32'h0,         0, 0, RUN,   4);
    tab_c[14] = mk(1, 0, 32'h0,         0, 0, 32'h0,         32'h100,       0, 0, BOOT,  0);
    tab_c[15] = mk(1, 1, 32'h400,       0, 1, 32'h100,       32'h104,       1, 0, RUN,   0);
    tab_c[16] = mk(1, 1, 32'h800,       0, 0, 32'h104,       32'h400,       1, 0, FLUSH, 1);
    tab_c[17] = mk(0, 1, 32'h2002,      0, 0, 32'h400,       32'h800,       0, 0, FLUSH, 2);
    tab_c[18] = mk(1, 0, 32'h0,         0, 0, 32'h0,         32'h100,       0, 0, BOOT,  0);
    tab_c[19] = mk(1, 0, 32'h0,         0, 1, 32'h100,       32'h104,       0, 0, RUN,   0);

    for (int i = 0; i < 10; i++) apply(tab_a[i]);

    // straight-line fetch up to pc_q=0x140
    for (int j = 1; j <= 10; j++) begin
      apply(mk(1, 0, 32'h0, 0, 1, 32'h110 + 32'(4 * j), 32'h114 + 32'(4 * j), 0, 0, RUN, 0));
    end

    for (int i = 0; i < 20; i++) apply(tab_c[i]);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_redirect.md
FETCH_REDIRECT -- requirements
Module: fetch_redirect

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk_i, input, 1, meaning the single clock; every flop is on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1, meaning the reset, which is synchronous and active-low.
REQ-004 SHALL have port pc_mux_sel_i, input, 1, meaning the redirect request from the execute-stage branch/jump resolver.
REQ-005 SHALL have port pc_taken_i, input, 32, meaning the redirect target address.
REQ-006 SHALL have port stall_i, input, 1, meaning the hazard-unit request to freeze fetch.
REQ-007 SHALL have port imem_rdata_i, input, 32, meaning the instruction word returned one cycle after imem_addr_o.
REQ-008 SHALL have port imem_addr_o, output, 32, meaning the synchronous instruction-memory read address, equal to pc_q.
REQ-009 SHALL have port if_pc_o, output, 32, meaning the PC of the instruction presented to IF/ID.
REQ-010 SHALL have port if_instr_o, output, 32, meaning the instruction presented to IF/ID.
REQ-011 SHALL have port if_valid_o, output, 1, meaning that if_pc_o/if_instr_o hold a real instruction.
REQ-012 SHALL have port flush_id_o, output, 1, meaning kill the IF/ID register contents.
REQ-013 SHALL have port flush_ex_o, output, 1, meaning kill the ID/EX register contents.
REQ-014 SHALL have port misalign_o, output, 1, meaning a one-cycle pulse when the redirect target has bits [1:0] != 0.

Function
REQ-015 SHALL run an FSM with states BOOT, RUN and FLUSH.
REQ-016 SHALL go BOOT -> RUN unconditionally after one cycle.
REQ-017 SHALL go RUN -> FLUSH on an accepted redirect.
REQ-018 SHALL go FLUSH -> RUN after one cycle, unless another redirect arrives, in which case it SHALL stay in FLUSH.
REQ-019 SHALL update pc_q as follows when neither redirect nor stall: pc_q <= pc_q + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-020 SHALL accept a redirect whenever pc_mux_sel_i=1, regardless of stall_i (redirect has priority), by loading pc_q <= {pc_taken_i[31:2], 2'b00}.
REQ-021 SHALL drive flush_id_o and flush_ex_o combinationally equal to pc_mux_sel_i in the same cycle.
REQ-022 SHALL drive misalign_o = pc_mux_sel_i & (pc_taken_i[1:0] != 0), registered, one cycle wide.
REQ-023 SHALL present fetch results with 1-cycle latency: if_pc_o is the registered copy of the previous imem_addr_o, and if_instr_o = imem_rdata_i.
REQ-024 SHALL drive if_valid_o=1 only in RUN, and 0 in BOOT and FLUSH; the in-flight fetch after a redirect is discarded.
REQ-025 SHALL, under stall_i=1 without redirect, hold pc_q, capture imem_rdata_i into the hold buffer on the first stall cycle, and drive if_instr_o, if_pc_o and if_valid_o from the buffer while the stall persists.
REQ-026 SHALL release the hold buffer on stall deassertion and resume from pc_q + 4 with no lost or duplicated instruction.
REQ-027 SHALL, for a redirect during a stall, drop the buffer contents and enter FLUSH.

Reset
REQ-028 SHALL, with rst_ni=0 at a clock edge, set pc_q=RESET_PC, state=BOOT and the hold buffer empty.
REQ-029 SHALL drive if_valid_o=0, if_pc_o=0 and misalign_o=0 from that edge, and misalign_o and the flush outputs SHALL be 0 while rst_ni=0.
REQ-030 SHALL let a reset mid-stall or mid-FLUSH override everything, and SHALL refetch RESET_PC on the first edge with rst_ni=1.

Configuration
REQ-031 SHALL, with macro FETCH_REDIRECT_CNT_EN defined, add output redirect_cnt_o[31:0]: a saturating count of accepted redirects (holds at 32'hFFFF_FFFF), reset to 0.
REQ-032 SHALL, with FETCH_REDIRECT_CNT_EN undefined, omit the port and the counter; all other behaviour is identical.

Structure
REQ-033 SHALL place RESET_PC default, the state enum (BOOT/RUN/FLUSH) and the opcode constants BRANCH 7'b1100011, JAL 7'b1101111 and JALR 7'b1100111 in shared package fetch_pkg, which is also used by the redirect resolver.
REQ-034 SHALL implement the stall hold register as sub-module fetch_hold_buf (capture/release/drop controls, 64-bit PC+instruction payload).

Verification
REQ-035 SHALL cover reset release with RESET_PC=32'h0000_0100: cycle 1 imem_addr_o=0x100 and if_valid_o=0; cycle 2 if_pc_o=0x100, if_valid_o=1, imem_addr_o=0x104.
REQ-036 SHALL cover a redirect with pc_taken_i=0x2000 at pc_q=0x140: flush_id_o=flush_ex_o=1 that cycle, next cycle if_valid_o=0 and imem_addr_o=0x2000, then if_pc_o=0x2000 valid.
REQ-037 SHALL cover stall_i=1 for 3 cycles at pc_q=0x10C: if_pc_o stays 0x108 valid with a constant instruction; after release the sequence is 0x10C, 0x110.
REQ-038 SHALL cover a simultaneous stall_i=1 and redirect to 0x3000: the redirect is taken, the buffer is dropped, and the next valid if_pc_o is 0x3000.
REQ-039 SHALL cover a redirect to 0x2002: misalign_o pulses for 1 cycle and the fetch address is 0x2000; pc_q=0xFFFF_FFFC wraps to fetch 0x0000_0000.
REQ-040 SHALL cover back-to-back redirects (0x400, then 0x800) plus rst_ni=0 mid-FLUSH: the FSM stays in FLUSH, only 0x800 issues, reset returns to RESET_PC, and with FETCH_REDIRECT_CNT_EN redirect_cnt_o=2 before the reset and 0 after it.
